// File: rtl/pipe_control_unit.sv
// pipe_control_unit: pipeline sequencer driving pipe-register enables/flushes, hazard stalls, memory freeze and halt drain
module pipe_control_unit #(
  parameter int TO_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             BranchTakenE,
  input  logic             HaltD,
  input  logic             MemReqM,
  input  logic             mem_ack,
  output logic             cargarF,
  output logic             cargarD,
  output logic             cargarE,
  output logic             cargarM,
  output logic             cargarW,
  output logic             flushD,
  output logic             flushE,
  output logic             running,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] stall_count
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;
  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [1:0]      drain_cnt;
  logic            mem_stall, hazard, run, drain, active;
  logic [4:0]      ld;
  assign mem_stall = MemReqM & ~mem_ack;
  assign hazard = (RegWriteE & (WA3E == RA1D | WA3E == RA2D)) |
                  (RegWriteM & (WA3M == RA1D | WA3M == RA2D));
  assign run     = state == RUN;
  assign drain   = state == DRAIN;
  assign active  = run | drain;
  assign running = active;
  assign halted  = state == HALTED;
  // Priority: memory freeze, branch squash, hazard bubble, halt entry, normal flow.
  assign ld = (!active || mem_stall) ? 5'b00000 :
              drain                  ? 5'b00111 :
              BranchTakenE           ? 5'b11111 :
              hazard                 ? 5'b00111 :
              HaltD                  ? 5'b01111 : 5'b11111;
  assign {cargarF, cargarD, cargarE, cargarM, cargarW} = ld;
  assign flushD = run & ~mem_stall & (BranchTakenE | (~hazard & HaltD));
  assign flushE = ~mem_stall & (drain | (run & (BranchTakenE | hazard)));
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      to_cnt      <= '0;
      drain_cnt   <= '0;
      error       <= 1'b0;
      stall_count <= '0;
    end else begin
      to_cnt <= (active & mem_stall) ? to_cnt + 1'b1 : '0;
      if (active & (mem_stall | (run & hazard & ~BranchTakenE)) & ~&stall_count)
        stall_count <= stall_count + 1'b1;
      if (state == IDLE && start)
        state <= RUN;
      else if (active && mem_stall && &to_cnt) begin
        state <= HALTED;
        error <= 1'b1;
      end else if (run && !mem_stall && !BranchTakenE && !hazard && HaltD) begin
        state     <= DRAIN;
        drain_cnt <= '0;
      end else if (drain && !mem_stall) begin
        drain_cnt <= drain_cnt + 1'b1;
        if (drain_cnt == 2'd2) state <= HALTED;
      end
    end
  end
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: directed scenario tests for pipe_control_unit with hand-computed expectations
module tb_pipe_control_unit;
  logic        clk, reset, start;
  logic [3:0]  RA1D, RA2D, WA3E, WA3M;
  logic        RegWriteE, RegWriteM, BranchTakenE, HaltD, MemReqM, mem_ack;
  logic        cargarF, cargarD, cargarE, cargarM, cargarW, flushD, flushE;
  logic        running, halted, error;
  logic [15:0] stall_count;
  logic        t_cF, t_cD, t_cE, t_cM, t_cW, t_fD, t_fE, t_running, t_halted, t_error;
  logic [15:0] t_stall_count;
  logic [4:0]  ld, t_ld;
  int          errors = 0;
  int          checks = 0;

  assign ld   = {cargarF, cargarD, cargarE, cargarM, cargarW};
  assign t_ld = {t_cF, t_cD, t_cE, t_cM, t_cW};

  pipe_control_unit u_dut (
    .clk(clk), .reset(reset), .start(start), .RA1D(RA1D), .RA2D(RA2D), .WA3E(WA3E), .WA3M(WA3M),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .BranchTakenE(BranchTakenE), .HaltD(HaltD),
    .MemReqM(MemReqM), .mem_ack(mem_ack), .cargarF(cargarF), .cargarD(cargarD), .cargarE(cargarE),
    .cargarM(cargarM), .cargarW(cargarW), .flushD(flushD), .flushE(flushE), .running(running),
    .halted(halted), .error(error), .stall_count(stall_count)
  );

  pipe_control_unit #(.TO_W(2)) u_to (
    .clk(clk), .reset(reset), .start(start), .RA1D(RA1D), .RA2D(RA2D), .WA3E(WA3E), .WA3M(WA3M),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .BranchTakenE(BranchTakenE), .HaltD(HaltD),
    .MemReqM(MemReqM), .mem_ack(mem_ack), .cargarF(t_cF), .cargarD(t_cD), .cargarE(t_cE),
    .cargarM(t_cM), .cargarW(t_cW), .flushD(t_fD), .flushE(t_fE), .running(t_running),
    .halted(t_halted), .error(t_error), .stall_count(t_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    start = 0; RA1D = 0; RA2D = 0; WA3E = 0; WA3M = 0; RegWriteE = 0; RegWriteM = 0;
    BranchTakenE = 0; HaltD = 0; MemReqM = 0; mem_ack = 0;
  endtask

  task automatic test_reset();
    clr();
    reset = 1;
    tick();
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) start = 1;
      #1;
      checks++;
      if ({ld, flushD, flushE, running, halted, error} !== 10'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 0", c, {ld, flushD, flushE, running, halted, error});
      end
      checks++;
      if (stall_count !== 16'd0) begin
        errors++;
        $display("FAIL reset_stall_count: got %0d expected 0", stall_count);
      end
      tick();
    end
    start = 0;
    #1;
    checks++;
    if (ld !== 5'b11111 || running !== 1'b1) begin
      errors++;
      $display("FAIL start_run: got ld=%b running=%b expected ld=11111 running=1", ld, running);
    end
    tick();
  endtask

  task automatic test_hazard();
    RA1D = 5; WA3E = 5; RegWriteE = 1;
    #1;
    checks++;
    if (ld !== 5'b00111 || flushE !== 1'b1 || flushD !== 1'b0) begin
      errors++;
      $display("FAIL hazard_e: got ld=%b fD=%b fE=%b expected 00111 0 1", ld, flushD, flushE);
    end
    tick();
    RA1D = 0; RA2D = 5; WA3E = 0; RegWriteE = 0; WA3M = 5; RegWriteM = 1;
    #1;
    checks++;
    if (ld !== 5'b00111 || flushE !== 1'b1) begin
      errors++;
      $display("FAIL hazard_m: got ld=%b fE=%b expected 00111 1", ld, flushE);
    end
    tick();
    clr();
    #1;
    checks++;
    if (ld !== 5'b11111 || flushE !== 1'b0 || stall_count !== 16'd2) begin
      errors++;
      $display("FAIL hazard_release: got ld=%b fE=%b stall=%0d expected 11111 0 2", ld, flushE, stall_count);
    end
    tick();
  endtask

  task automatic test_branch();
    RA1D = 3; WA3E = 3; RegWriteE = 1; BranchTakenE = 1;
    #1;
    checks++;
    if (ld !== 5'b11111 || flushD !== 1'b1 || flushE !== 1'b1) begin
      errors++;
      $display("FAIL branch_over_hazard: got ld=%b fD=%b fE=%b expected 11111 1 1", ld, flushD, flushE);
    end
    tick();
    clr();
    #1;
    checks++;
    if (stall_count !== 16'd2) begin
      errors++;
      $display("FAIL branch_stall_count: got %0d expected 2", stall_count);
    end
    tick();
  endtask

  task automatic test_mem();
    MemReqM = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (ld !== 5'b00000 || flushD !== 1'b0 || flushE !== 1'b0) begin
        errors++;
        $display("FAIL mem_freeze cycle %0d: got ld=%b fD=%b fE=%b expected 00000 0 0", c, ld, flushD, flushE);
      end
      tick();
    end
    mem_ack = 1;
    #1;
    checks++;
    if (ld !== 5'b11111) begin
      errors++;
      $display("FAIL mem_ack_cycle: got ld=%b expected 11111", ld);
    end
    tick();
    clr();
    #1;
    checks++;
    if (stall_count !== 16'd6 || error !== 1'b0) begin
      errors++;
      $display("FAIL mem_stall_count: got %0d err=%b expected 6 0", stall_count, error);
    end
  endtask

  task automatic test_halt();
    HaltD = 1;
    #1;
    checks++;
    if (ld !== 5'b01111 || flushD !== 1'b1 || flushE !== 1'b0) begin
      errors++;
      $display("FAIL halt_entry: got ld=%b fD=%b fE=%b expected 01111 1 0", ld, flushD, flushE);
    end
    tick();
    HaltD = 0;
    #1;
    checks++;
    if (ld !== 5'b00111 || flushE !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("FAIL drain1: got ld=%b fE=%b run=%b expected 00111 1 1", ld, flushE, running);
    end
    tick();
    MemReqM = 1; HaltD = 1; BranchTakenE = 1;
    #1;
    checks++;
    if (ld !== 5'b00000 || flushE !== 1'b0) begin
      errors++;
      $display("FAIL drain_stall: got ld=%b fE=%b expected 00000 0", ld, flushE);
    end
    tick();
    clr();
    BranchTakenE = 1; HaltD = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (ld !== 5'b00111 || flushD !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL drain_late %0d: got ld=%b fD=%b halted=%b expected 00111 0 0", c, ld, flushD, halted);
      end
      tick();
    end
    clr();
    #1;
    checks++;
    if (halted !== 1'b1 || running !== 1'b0 || ld !== 5'b00000 || stall_count !== 16'd7) begin
      errors++;
      $display("FAIL halted: got halted=%b run=%b ld=%b stall=%0d expected 1 0 00000 7", halted, running, ld, stall_count);
    end
    start = 1;
    tick();
    tick();
    start = 0;
    #1;
    checks++;
    if (halted !== 1'b1 || ld !== 5'b00000) begin
      errors++;
      $display("FAIL halted_ignores_start: got halted=%b ld=%b expected 1 00000", halted, ld);
    end
  endtask

  task automatic test_timeout();
    clr();
    reset = 1;
    tick();
    reset = 0;
    #1;
    checks++;
    if (t_error !== 1'b0 || t_halted !== 1'b0 || halted !== 1'b0 || stall_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_op: got t_err=%b t_halt=%b halt=%b stall=%0d expected 0 0 0 0", t_error, t_halted, halted, stall_count);
    end
    start = 1;
    tick();
    start = 0;
    MemReqM = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (t_halted !== 1'b0 || t_running !== 1'b1 || t_ld !== 5'b00000) begin
        errors++;
        $display("FAIL timeout_wait %0d: got halt=%b run=%b ld=%b expected 0 1 00000", c, t_halted, t_running, t_ld);
      end
      tick();
    end
    #1;
    checks++;
    if (t_halted !== 1'b1 || t_error !== 1'b1 || error !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: got t_halt=%b t_err=%b err=%b run=%b expected 1 1 0 1", t_halted, t_error, error, running);
    end
    clr();
    reset = 1;
    tick();
    reset = 0;
    #1;
    checks++;
    if (t_halted !== 1'b0 || t_error !== 1'b0 || t_ld !== 5'b00000) begin
      errors++;
      $display("FAIL timeout_reset: got halt=%b err=%b ld=%b expected 0 0 00000", t_halted, t_error, t_ld);
    end
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_branch();
    test_mem();
    test_halt();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
